matrix_result_reader: RTL and testbench

//   Downstream stage of the matrix operation unit. Once the result write

---
 rtl/matrix_pkg.sv | 20 ++
 rtl/matrix_elem_serializer.sv | 78 +++++++
 rtl/matrix_result_reader.sv | 165 ++++++++++++++++
 tb/tb_matrix_result_reader.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - matrix unit constants and result reader state encoding
package matrix_pkg;

  localparam int MAT_ELEM_W      = 8;
  localparam int MAT_DIM         = 5;
  localparam int MAT_ADDR_W      = 8;
  localparam int MAT_WORD_W      = 256;
  localparam int MAT_RESULT_ADDR = 2;
  localparam int MAT_RAM_LATENCY = 2;

  typedef enum logic [2:0] {
    RD_IDLE = 3'd0,
    RD_ADDR = 3'd1,
    RD_WAIT = 3'd2,
    RD_LOAD = 3'd3,
    RD_EMIT = 3'd4,
    RD_DONE = 3'd5
  } reader_state_e;

endpackage

// File: rtl/matrix_elem_serializer.sv
// rtl/matrix_elem_serializer.sv - unpacks a result word into a row-major element stream
module matrix_elem_serializer #(
  parameter int ELEM_W = 8,
  parameter int DIM    = 5
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      load_i,
  input  logic [DIM*DIM*ELEM_W-1:0] word_i,
  input  logic                      scalar_i,
  input  logic                      ready_i,
  output logic                      valid_o,
  output logic [ELEM_W-1:0]         data_o,
  output logic [2:0]                row_o,
  output logic [2:0]                col_o,
  output logic                      last_hs_o
);

  localparam int         RES_W    = DIM*DIM*ELEM_W;
  localparam logic [2:0] LAST_IDX = 3'(DIM-1);

  logic [RES_W-1:0] shift_q, shift_d;
  logic [2:0]       row_q, row_d;
  logic [2:0]       col_q, col_d;
  logic             valid_q, valid_d;
  logic             hs;
  logic             is_last;

  // Load the word, then on each handshake drop the low element and step row/col.
  always_comb begin
    shift_d   = shift_q;
    row_d     = row_q;
    col_d     = col_q;
    valid_d   = valid_q;
    hs        = valid_q && ready_i;
    is_last   = scalar_i || ((row_q == LAST_IDX) && (col_q == LAST_IDX));
    last_hs_o = hs && is_last;
    if (load_i) begin
      shift_d = word_i;
      row_d   = 3'd0;
      col_d   = 3'd0;
      valid_d = 1'b1;
    end else if (hs) begin
      if (is_last) begin
        valid_d = 1'b0;
      end else begin
        shift_d = shift_q >> ELEM_W;
        if (col_q == LAST_IDX) begin
          col_d = 3'd0;
          row_d = row_q + 3'd1;
        end else begin
          col_d = col_q + 3'd1;
        end
      end
    end
  end

  // Element registers: held unchanged while the consumer stalls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shift_q <= '0;
      row_q   <= 3'd0;
      col_q   <= 3'd0;
      valid_q <= 1'b0;
    end else begin
      shift_q <= shift_d;
      row_q   <= row_d;
      col_q   <= col_d;
      valid_q <= valid_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = shift_q[ELEM_W-1:0];
  assign row_o   = row_q;
  assign col_o   = col_q;

endmodule

// File: rtl/matrix_result_reader.sv
// rtl/matrix_result_reader.sv - result RAM readout FSM; optional element checksum under READER_CHECKSUM_EN
module matrix_result_reader
  import matrix_pkg::*;
#(
  parameter int ELEM_W      = MAT_ELEM_W,
  parameter int DIM         = MAT_DIM,
  parameter int ADDR_W      = MAT_ADDR_W,
  parameter int WORD_W      = MAT_WORD_W,
  parameter int RESULT_ADDR = MAT_RESULT_ADDR,
  parameter int RAM_LATENCY = MAT_RAM_LATENCY
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              scalar_only,
  output logic [ADDR_W-1:0] ram_address,
  input  logic [WORD_W-1:0] ram_q,
  output logic              elem_valid,
  input  logic              elem_ready,
  output logic [ELEM_W-1:0] elem_data,
  output logic [2:0]        elem_row,
  output logic [2:0]        elem_col,
  output logic              busy,
  output logic              done,
  output logic [ELEM_W-1:0] checksum
);

  localparam int RES_W = DIM*DIM*ELEM_W;
  localparam int CNT_W = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;

  if (DIM > 7) begin : g_dim_too_big
    $error("matrix_result_reader: DIM must not exceed 7 (3-bit indices)");
  end
  if (RES_W > WORD_W) begin : g_word_too_small
    $error("matrix_result_reader: result does not fit in WORD_W");
  end
  if (RAM_LATENCY < 1) begin : g_bad_latency
    $error("matrix_result_reader: RAM_LATENCY must be >= 1");
  end

  reader_state_e     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              scalar_q, scalar_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              accept;
  logic              load;
  logic              last_hs;

  assign accept = (state_q == RD_IDLE) && start;

  // Readout sequencing: address the result, wait out the RAM, load, stream, finish.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    scalar_d = scalar_q;
    busy_d   = busy_q;
    addr_d   = addr_q;
    load     = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (accept) begin
          scalar_d = scalar_only;
          addr_d   = ADDR_W'(RESULT_ADDR);
          busy_d   = 1'b1;
          state_d  = RD_ADDR;
        end
      end
      RD_ADDR: begin
        cnt_d   = CNT_W'(RAM_LATENCY - 1);
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        // Leave as the count reaches zero so the capture edge lands RAM_LATENCY+2 after start.
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = RD_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RD_LOAD: begin
        load    = 1'b1;
        state_d = RD_EMIT;
      end
      RD_EMIT: begin
        if (last_hs) state_d = RD_DONE;
      end
      RD_DONE: begin
        busy_d  = 1'b0;
        addr_d  = '0;
        state_d = RD_IDLE;
      end
      default: state_d = RD_IDLE;
    endcase
  end

  // FSM and RAM-interface registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= RD_IDLE;
      cnt_q    <= '0;
      scalar_q <= 1'b0;
      busy_q   <= 1'b0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      scalar_q <= scalar_d;
      busy_q   <= busy_d;
      addr_q   <= addr_d;
    end
  end

  assign ram_address = addr_q;
  assign busy        = busy_q;
  assign done        = (state_q == RD_DONE);

  if (RES_W < WORD_W) begin : g_unused_q
    logic unused_q_bits;
    assign unused_q_bits = ^ram_q[WORD_W-1:RES_W];
  end

  matrix_elem_serializer #(
    .ELEM_W (ELEM_W),
    .DIM    (DIM)
  ) u_serializer (
    .clock     (clock),
    .reset_n   (reset_n),
    .load_i    (load),
    .word_i    (ram_q[RES_W-1:0]),
    .scalar_i  (scalar_q),
    .ready_i   (elem_ready),
    .valid_o   (elem_valid),
    .data_o    (elem_data),
    .row_o     (elem_row),
    .col_o     (elem_col),
    .last_hs_o (last_hs)
  );

`ifdef READER_CHECKSUM_EN
  logic [ELEM_W-1:0] cks_q, cks_d;

  // Sum clears when a readout is accepted and holds after done until the next one.
  always_comb begin
    cks_d = cks_q;
    if (accept) begin
      cks_d = '0;
    end else if (elem_valid && elem_ready) begin
      cks_d = cks_q + elem_data;
    end
  end

  // Checksum register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cks_q <= '0;
    else          cks_q <= cks_d;
  end

  assign checksum = cks_q;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_matrix_result_reader.sv
// tb/tb_matrix_result_reader.sv - directed table-driven bench for matrix_result_reader
module tb_matrix_result_reader;

  localparam int ELEM_W = 8;
  localparam int ADDR_W = 8;
  localparam int WORD_W = 256;
  localparam int NEL    = 25;
  localparam logic [ADDR_W-1:0] RES_ADDR = 8'd2;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              scalar_only = 1'b0;
  logic [ADDR_W-1:0] ram_address;
  logic [WORD_W-1:0] ram_q = '0;
  logic              elem_valid;
  logic              elem_ready = 1'b0;
  logic [ELEM_W-1:0] elem_data;
  logic [2:0]        elem_row;
  logic [2:0]        elem_col;
  logic              busy;
  logic              done;
  logic [ELEM_W-1:0] checksum;

  logic [WORD_W-1:0] mem_word = '0;
  logic [WORD_W-1:0] rd_p1 = '0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         id;
    bit         scalar;
    int         ready_mode;
    int         byte_rule;
    bit         restart;
    int         exp_count;
    logic [7:0] exp_cks;
    int         exp_span;
  } vec_t;

  vec_t tbl[5];

  matrix_result_reader dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .scalar_only (scalar_only),
    .ram_address (ram_address),
    .ram_q       (ram_q),
    .elem_valid  (elem_valid),
    .elem_ready  (elem_ready),
    .elem_data   (elem_data),
    .elem_row    (elem_row),
    .elem_col    (elem_col),
    .busy        (busy),
    .done        (done),
    .checksum    (checksum)
  );

  always #5 clock = ~clock;

  // Two-clock read RAM: only RESULT_ADDR holds the result word.
  always @(posedge clock) begin
    rd_p1 <= (ram_address == RES_ADDR) ? mem_word : {32{8'hC3}};
    ram_q <= rd_p1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WORD_W-1:0] build(input int rule);
    logic [WORD_W-1:0] w;
    w = {32{8'h5A}};
    for (int k = 0; k < NEL; k++) begin
      case (rule)
        0:       w[k*8 +: 8] = 8'(k + 1);
        1:       w[k*8 +: 8] = (k == 0) ? 8'hF6 : 8'hAA;
        default: w[k*8 +: 8] = 8'(8'h80 + k);
      endcase
    end
    return w;
  endfunction

  task automatic run_vec(input vec_t v);
    logic [WORD_W-1:0] w;
    int n, lat, dones, first_hs, last_hs, extra;
    bit stalled, restarted;
    logic [7:0] pd, exp_c;
    logic [2:0] pr, pc;
    w = build(v.byte_rule);
    mem_word = w;
    tick(); tick(); tick();
    scalar_only = v.scalar;
    start = 1'b1;
    elem_ready = 1'b0;
    tick();
    start = 1'b0;
    scalar_only = 1'b0;
    check($sformatf("v%0d_busy_after_start", v.id), busy, 1);
    check($sformatf("v%0d_addr_after_start", v.id), ram_address, RES_ADDR);
    lat = 1;
    while (!elem_valid && lat < 20) begin
      tick();
      lat++;
    end
    check($sformatf("v%0d_first_valid_latency", v.id), lat, 4);

    n = 0; dones = 0; first_hs = -1; last_hs = -1;
    stalled = 0; restarted = 0; pd = '0; pr = '0; pc = '0;
    for (int cyc = 0; cyc < 300 && dones == 0; cyc++) begin
      case (v.ready_mode)
        0:       elem_ready = 1'b1;
        1:       elem_ready = (cyc % 2 == 0);
        default: elem_ready = (cyc % 3 != 2);
      endcase
      if (stalled) begin
        check($sformatf("v%0d_stall_data", v.id), elem_data, pd);
        check($sformatf("v%0d_stall_pos", v.id), {elem_row, elem_col}, {pr, pc});
        check($sformatf("v%0d_stall_valid", v.id), elem_valid, 1);
      end
      stalled = 0;
      if (elem_valid) begin
        if (elem_ready) begin
          if (n < NEL) begin
            check($sformatf("v%0d_e%0d_data", v.id, n), elem_data, w[n*8 +: 8]);
            check($sformatf("v%0d_e%0d_row", v.id, n), elem_row, n / 5);
            check($sformatf("v%0d_e%0d_col", v.id, n), elem_col, n % 5);
          end
          if (first_hs < 0) first_hs = cyc;
          last_hs = cyc;
          n++;
        end else begin
          stalled = 1;
          pd = elem_data; pr = elem_row; pc = elem_col;
        end
      end
      if (v.restart && n == 5 && !restarted) begin
        start = 1'b1;
        restarted = 1;
      end
      tick();
      start = 1'b0;
      if (done) dones++;
    end
    exp_c = '0;
`ifdef READER_CHECKSUM_EN
    exp_c = v.exp_cks;
`endif
    check($sformatf("v%0d_done_seen", v.id), dones, 1);
    check($sformatf("v%0d_elem_count", v.id), n, v.exp_count);
    check($sformatf("v%0d_checksum", v.id), checksum, exp_c);
    check($sformatf("v%0d_valid_at_done", v.id), elem_valid, 0);
    if (v.exp_span > 0)
      check($sformatf("v%0d_hs_span", v.id), last_hs - first_hs + 1, v.exp_span);
    elem_ready = 1'b1;
    tick();
    check($sformatf("v%0d_done_one_cycle", v.id), done, 0);
    check($sformatf("v%0d_busy_cleared", v.id), busy, 0);
    check($sformatf("v%0d_addr_cleared", v.id), ram_address, 0);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      if (elem_valid || done) extra++;
      tick();
    end
    check($sformatf("v%0d_quiet_after_done", v.id), extra, 0);
    check($sformatf("v%0d_checksum_held", v.id), checksum, exp_c);
    elem_ready = 1'b0;
  endtask

  initial begin
    int n, guard, extra;
    tbl[0] = '{id: 0, scalar: 0, ready_mode: 0, byte_rule: 0, restart: 0, exp_count: 25, exp_cks: 8'h45, exp_span: 25};
    tbl[1] = '{id: 1, scalar: 0, ready_mode: 1, byte_rule: 0, restart: 0, exp_count: 25, exp_cks: 8'h45, exp_span: 49};
    tbl[2] = '{id: 2, scalar: 1, ready_mode: 0, byte_rule: 1, restart: 0, exp_count: 1,  exp_cks: 8'hF6, exp_span: 1};
    tbl[3] = '{id: 3, scalar: 0, ready_mode: 0, byte_rule: 0, restart: 1, exp_count: 25, exp_cks: 8'h45, exp_span: 25};
    tbl[4] = '{id: 4, scalar: 0, ready_mode: 2, byte_rule: 2, restart: 0, exp_count: 25, exp_cks: 8'hAC, exp_span: -1};

    reset_n = 1'b0;
    tick(); tick();
    check("reset_valid", elem_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_addr", ram_address, 0);
    check("reset_data", elem_data, 0);
    check("reset_checksum", checksum, 0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) run_vec(tbl[i]);

    // Reset in the middle of a readout, at element 10.
    mem_word = build(0);
    tick(); tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    elem_ready = 1'b1;
    n = 0; guard = 0;
    while (n < 10 && guard < 100) begin
      if (elem_valid) n++;
      tick();
      guard++;
    end
    check("t5_reached_elem10", n, 10);
    check("t5_elem10_data", elem_data, 8'h0B);
    reset_n = 1'b0;
    #1;
    check("t5_abort_valid", elem_valid, 0);
    check("t5_abort_busy", busy, 0);
    check("t5_abort_addr", ram_address, 0);
    check("t5_abort_data", elem_data, 0);
    check("t5_abort_pos", {elem_row, elem_col}, 0);
    check("t5_abort_checksum", checksum, 0);
    extra = 0;
    tick();
    if (done) extra++;
    tick();
    if (done) extra++;
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (done || elem_valid || busy) extra++;
      tick();
    end
    check("t5_no_done_after_abort", extra, 0);
    elem_ready = 1'b0;
    run_vec(tbl[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
